// File: rtl/rast_span_filler_if.sv
// Span command handshake plus rasterizer-to-framebuffer-writer FIFO write port.
// The slave modport is the span filler; the master modport is the surrounding logic or bench.
interface rast_span_filler_if #(
    parameter int unsigned LINE_LEN          = 9,
    parameter int unsigned COL_LEN           = 10,
    parameter int unsigned RAST_FBW_FIFO_LEN = 64,
    parameter int unsigned CNT_LEN           = 16
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [LINE_LEN-1:0]            cmd_line;
    logic [COL_LEN-1:0]             cmd_col0;
    logic [COL_LEN-1:0]             cmd_col1;
    logic [31:0]                    cmd_color;
    logic [0:RAST_FBW_FIFO_LEN-1]   fifo_data;
    logic                           fifo_wr_en;
    logic                           fifo_full;
    logic                           busy;
    logic [CNT_LEN-1:0]             pix_count;

    modport master (
        output cmd_valid, cmd_line, cmd_col0, cmd_col1, cmd_color, fifo_full,
        input  cmd_ready, fifo_data, fifo_wr_en, busy, pix_count
    );

    modport slave (
        input  cmd_valid, cmd_line, cmd_col0, cmd_col1, cmd_color, fifo_full,
        output cmd_ready, fifo_data, fifo_wr_en, busy, pix_count
    );
endinterface

// File: rtl/rast_span_filler.sv
// Expands one horizontal span command into one packed pixel word per column for the FBW FIFO.
// Defining RAST_SPAN_CLIP_EN clamps spans to columns 0..H_MAX and drops fully invisible spans.
module rast_span_filler #(
    parameter int unsigned LINE_LEN          = 9,
    parameter int unsigned COL_LEN           = 10,
    parameter int unsigned RAST_FBW_FIFO_LEN = 64,
    parameter int unsigned H_MAX             = 639,
    parameter int unsigned CNT_LEN           = 16
) (
    input  logic              PLB_clk,
    input  logic              Bus2IP_Reset,
    rast_span_filler_if.slave bus
);

    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_EMIT    = 1'b1;
    localparam int unsigned COLOR_LEN = 32;
    localparam int unsigned COLOR_POS = RAST_FBW_FIFO_LEN - COLOR_LEN;

    logic [0:0]                   state_q,   state_d;
    logic [LINE_LEN-1:0]          line_q,    line_d;
    logic [COL_LEN-1:0]           cur_col_q, cur_col_d;
    logic [COL_LEN-1:0]           end_col_q, end_col_d;
    logic [COLOR_LEN-1:0]         color_q,   color_d;
    logic [CNT_LEN-1:0]           pix_cnt_q, pix_cnt_d;

    logic                         cmd_ready_c;
    logic                         wr_en_c;
    logic                         accept_c;
    logic [COL_LEN-1:0]           col_lo_c;
    logic [COL_LEN-1:0]           col_hi_c;
    logic [COL_LEN-1:0]           span_end_c;
    logic                         span_skip_c;
    logic [0:RAST_FBW_FIFO_LEN-1] word_c;

    // Handshake and write strobe are combinational so a stall costs no extra cycle.
    assign cmd_ready_c = (state_q == S_IDLE) && !Bus2IP_Reset;
    assign accept_c    = bus.cmd_valid && cmd_ready_c;
    assign wr_en_c     = (state_q == S_EMIT) && !bus.fifo_full && !Bus2IP_Reset;

    // Endpoints may arrive in either order; emission always runs low to high.
    assign col_lo_c = (bus.cmd_col0 <= bus.cmd_col1) ? bus.cmd_col0 : bus.cmd_col1;
    assign col_hi_c = (bus.cmd_col0 <= bus.cmd_col1) ? bus.cmd_col1 : bus.cmd_col0;

`ifdef RAST_SPAN_CLIP_EN
    localparam logic [COL_LEN-1:0] CLIP_COL = COL_LEN'(H_MAX);

    assign span_end_c  = (col_hi_c > CLIP_COL) ? CLIP_COL : col_hi_c;
    assign span_skip_c = (col_lo_c > CLIP_COL);
`else
    assign span_end_c  = col_hi_c;
    assign span_skip_c = 1'b0;
`endif

    // Big-endian packing: line at bit 0, column next, zero pad, colour in the low word.
    always_comb begin
        word_c                          = '0;
        word_c[0 +: LINE_LEN]           = line_q;
        word_c[LINE_LEN +: COL_LEN]     = cur_col_q;
        word_c[COLOR_POS +: COLOR_LEN]  = color_q;
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        cur_col_d = cur_col_q;
        end_col_d = end_col_q;
        color_d   = color_q;
        pix_cnt_d = pix_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    line_d    = bus.cmd_line;
                    color_d   = bus.cmd_color;
                    cur_col_d = col_lo_c;
                    end_col_d = span_end_c;
                    if (!span_skip_c) begin
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (wr_en_c) begin
                    pix_cnt_d = pix_cnt_q + CNT_LEN'(1);
                    // Compare before incrementing so the column counter never wraps.
                    if (cur_col_q == end_col_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_col_d = cur_col_q + COL_LEN'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge PLB_clk) begin
        if (Bus2IP_Reset) begin
            state_q   <= S_IDLE;
            line_q    <= '0;
            cur_col_q <= '0;
            end_col_q <= '0;
            color_q   <= '0;
            pix_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            cur_col_q <= cur_col_d;
            end_col_q <= end_col_d;
            color_q   <= color_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.fifo_wr_en = wr_en_c;
    assign bus.fifo_data  = word_c;
    assign bus.busy       = (state_q == S_EMIT);
    assign bus.pix_count  = pix_cnt_q;

endmodule

// File: tb/tb_rast_span_filler.sv
// Bench for rast_span_filler: table of spans with stall patterns, scoreboard of expected words,
// plus hand-written reset and full-range sequences. Honours RAST_SPAN_CLIP_EN like the RTL.
module tb_rast_span_filler;

    localparam int unsigned LINE_LEN = 9;
    localparam int unsigned COL_LEN  = 10;
    localparam int unsigned FW       = 64;
    localparam int unsigned CNT_LEN  = 16;
    localparam int unsigned H_MAX    = 639;

    logic PLB_clk = 1'b0;
    logic Bus2IP_Reset;

    rast_span_filler_if #(
        .LINE_LEN(LINE_LEN), .COL_LEN(COL_LEN), .RAST_FBW_FIFO_LEN(FW), .CNT_LEN(CNT_LEN)
    ) bus ();

    rast_span_filler #(
        .LINE_LEN(LINE_LEN), .COL_LEN(COL_LEN), .RAST_FBW_FIFO_LEN(FW),
        .H_MAX(H_MAX), .CNT_LEN(CNT_LEN)
    ) dut (
        .PLB_clk      (PLB_clk),
        .Bus2IP_Reset (Bus2IP_Reset),
        .bus          (bus)
    );

    always #5 PLB_clk = ~PLB_clk;

    typedef logic [0:FW-1] word_t;

    typedef struct {
        logic [LINE_LEN-1:0] line;
        logic [COL_LEN-1:0]  c0;
        logic [COL_LEN-1:0]  c1;
        logic [31:0]         color;
        int                  full_at;   // writes completed before fifo_full is raised
        int                  full_len;  // stall cycles
        int                  exp_n;     // words the span must produce
    } vec_t;

    word_t              exp_q[$];
    int                 n_checks = 0;
    int                 n_pass   = 0;
    logic [CNT_LEN-1:0] exp_pix  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic word_t make_word(input logic [LINE_LEN-1:0] line,
                                        input logic [COL_LEN-1:0] col,
                                        input logic [31:0] color);
        word_t w;
        w = '0;
        w[0:LINE_LEN-1]                 = line;
        w[LINE_LEN:LINE_LEN+COL_LEN-1]  = col;
        w[32:63]                        = color;
        return w;
    endfunction

    // Reference model: push the words a span should produce, in emission order.
    task automatic push_span(input logic [LINE_LEN-1:0] line, input logic [COL_LEN-1:0] c0,
                             input logic [COL_LEN-1:0] c1, input logic [31:0] color);
        int lo, hi;
        lo = (int'(c0) < int'(c1)) ? int'(c0) : int'(c1);
        hi = (int'(c0) < int'(c1)) ? int'(c1) : int'(c0);
`ifdef RAST_SPAN_CLIP_EN
        if (hi > int'(H_MAX)) hi = int'(H_MAX);
`endif
        for (int c = lo; c <= hi; c++) exp_q.push_back(make_word(line, COL_LEN'(c), color));
    endtask

    // Called at a negedge: score a write if one is being presented.
    task automatic observe(output bit wrote);
        word_t e;
        wrote = 1'b0;
        if (bus.fifo_wr_en === 1'b1) begin
            wrote = 1'b1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got data 0x%0h, no word expected", bus.fifo_data);
            end else begin
                e = exp_q.pop_front();
                chk("word", bus.fifo_data, e);
            end
        end
    endtask

    task automatic run_span(input vec_t v, input string name);
        int writes, busy_cyc, stalls;
        bit done, w;
        @(posedge PLB_clk); #1;
        push_span(v.line, v.c0, v.c1, v.color);
        bus.cmd_valid = 1'b1;
        bus.cmd_line  = v.line;
        bus.cmd_col0  = v.c0;
        bus.cmd_col1  = v.c1;
        bus.cmd_color = v.color;
        bus.fifo_full = 1'b0;
        @(negedge PLB_clk);
        chk({name, "_accept_ready"}, bus.cmd_ready, 1);
        observe(w);
        writes = 0; busy_cyc = 0; stalls = 0; done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(posedge PLB_clk); #1;
            // Garbage on the command bus while busy must be ignored.
            bus.cmd_valid = bus.busy;
            bus.cmd_line  = LINE_LEN'($urandom);
            bus.cmd_col0  = COL_LEN'($urandom);
            bus.cmd_col1  = COL_LEN'($urandom);
            bus.cmd_color = $urandom;
            bus.fifo_full = bus.busy && (writes == v.full_at) && (stalls < v.full_len);
            if (bus.fifo_full) stalls++;
            @(negedge PLB_clk);
            if (bus.busy) busy_cyc++;
            if (bus.fifo_full) begin
                chk({name, "_stall_wr_en"}, bus.fifo_wr_en, 0);
                if (exp_q.size() > 0) chk({name, "_stall_hold"}, bus.fifo_data, exp_q[0]);
            end
            if (cyc == 0 && v.exp_n > 0 && !bus.fifo_full)
                chk({name, "_first_write_latency"}, bus.fifo_wr_en, 1);
            observe(w);
            if (w) writes++;
            if (!bus.busy) done = 1'b1;
        end
        bus.fifo_full = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL %s_timeout: busy still high after 3000 cycles, required low", name);
        end
        exp_pix = exp_pix + CNT_LEN'(v.exp_n);
        chk({name, "_writes"}, writes, v.exp_n);
        chk({name, "_busy_cycles"}, busy_cyc, v.exp_n + v.full_len);
        chk({name, "_ready_after"}, bus.cmd_ready, 1);
        chk({name, "_pix_count"}, bus.pix_count, exp_pix);
        chk({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        vec_t extra;
        int   writes;
        bit   w;

        tbl[0] = '{line: 9'd5,   c0: 10'd10,   c1: 10'd13,   color: 32'hFF00FF00, full_at: 0, full_len: 0, exp_n: 4};
        tbl[1] = '{line: 9'd3,   c0: 10'd20,   c1: 10'd18,   color: 32'h12345678, full_at: 0, full_len: 0, exp_n: 3};
        tbl[2] = '{line: 9'd1,   c0: 10'd7,    c1: 10'd7,    color: 32'hA5A5A5A5, full_at: 0, full_len: 0, exp_n: 1};
        tbl[3] = '{line: 9'd0,   c0: 10'd0,    c1: 10'd3,    color: 32'hDEADBEEF, full_at: 1, full_len: 3, exp_n: 4};
`ifdef RAST_SPAN_CLIP_EN
        tbl[4] = '{line: 9'd200, c0: 10'd636,  c1: 10'd700,  color: 32'h0F0F0F0F, full_at: 0, full_len: 0, exp_n: 4};
`else
        tbl[4] = '{line: 9'd511, c0: 10'd1023, c1: 10'd1020, color: 32'h0F0F0F0F, full_at: 0, full_len: 0, exp_n: 4};
`endif
        tbl[5] = '{line: 9'd100, c0: 10'd5,    c1: 10'd0,    color: 32'h80000001, full_at: 0, full_len: 2, exp_n: 6};

        bus.cmd_valid = 1'b0;
        bus.cmd_line  = '0;
        bus.cmd_col0  = '0;
        bus.cmd_col1  = '0;
        bus.cmd_color = '0;
        bus.fifo_full = 1'b0;
        Bus2IP_Reset  = 1'b1;

        // Reset behaviour.
        @(negedge PLB_clk);
        chk("reset_cycle_ready", bus.cmd_ready, 0);
        chk("reset_cycle_wr_en", bus.fifo_wr_en, 0);
        @(posedge PLB_clk); #1;
        Bus2IP_Reset = 1'b0;
        @(negedge PLB_clk);
        chk("post_reset_ready", bus.cmd_ready, 1);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_wr_en", bus.fifo_wr_en, 0);
        chk("post_reset_data", bus.fifo_data, 0);
        chk("post_reset_pix", bus.pix_count, 0);

        for (int i = 0; i < 6; i++) run_span(tbl[i], $sformatf("span%0d", i));

`ifdef RAST_SPAN_CLIP_EN
        extra = '{line: 9'd7, c0: 10'd700, c1: 10'd710, color: 32'h11111111, full_at: 0, full_len: 0, exp_n: 0};
        run_span(extra, "clip_invisible");
        extra = '{line: 9'd8, c0: 10'd710, c1: 10'd600, color: 32'h22222222, full_at: 0, full_len: 0, exp_n: 40};
        run_span(extra, "clip_reversed");
`else
        extra = '{line: 9'd2, c0: 10'd0, c1: 10'd1023, color: 32'hCAFEF00D, full_at: 0, full_len: 0, exp_n: 1024};
        run_span(extra, "full_width");
`endif

        // Reset two pixels into a six-pixel span.
        @(posedge PLB_clk); #1;
        push_span(9'd9, 10'd2, 10'd7, 32'h0BADCAFE);
        bus.cmd_valid = 1'b1;
        bus.cmd_line  = 9'd9;
        bus.cmd_col0  = 10'd2;
        bus.cmd_col1  = 10'd7;
        bus.cmd_color = 32'h0BADCAFE;
        @(negedge PLB_clk);
        observe(w);
        writes = 0;
        for (int cyc = 0; cyc < 20 && writes < 2; cyc++) begin
            @(posedge PLB_clk); #1;
            bus.cmd_valid = 1'b0;
            @(negedge PLB_clk);
            observe(w);
            if (w) writes++;
        end
        chk("midrst_pre_writes", writes, 2);
        @(posedge PLB_clk); #1;
        Bus2IP_Reset = 1'b1;
        @(negedge PLB_clk);
        chk("midrst_no_write", bus.fifo_wr_en, 0);
        chk("midrst_ready_low", bus.cmd_ready, 0);
        @(posedge PLB_clk); #1;
        Bus2IP_Reset = 1'b0;
        exp_q.delete();
        exp_pix = '0;
        @(negedge PLB_clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_pix", bus.pix_count, 0);
        chk("midrst_ready", bus.cmd_ready, 1);
        writes = 0;
        repeat (6) begin
            @(negedge PLB_clk);
            observe(w);
            if (w) writes++;
        end
        chk("midrst_no_more_words", writes, 0);

        // Normal operation resumes after the reset.
        run_span(tbl[0], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
